mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/riscv_pkg.sv | 19 +
 rtl/arb_grant.sv | 27 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner IDs and grant bit positions.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

  localparam int unsigned GRANT_W   = 2;
  localparam int unsigned GNT_FETCH = 0;
  localparam int unsigned GNT_DATA  = 1;

endpackage

// File: rtl/arb_grant.sv
// Combinational winner selection between the fetch and data requesters.
// RR_EN=1: a tie goes to the requester not granted last; RR_EN=0: data wins ties.
module arb_grant
  import riscv_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic               if_valid,
  input  logic               d_valid,
  input  owner_t             last_grant,
  output logic [GRANT_W-1:0] grant
);

  // One-hot grant; empty when nobody requests.
  always_comb begin
    grant = '0;
    if (if_valid && d_valid) begin
      if (RR_EN && (last_grant == DATA)) grant[GNT_FETCH] = 1'b1;
      else                               grant[GNT_DATA]  = 1'b1;
    end else if (d_valid) begin
      grant[GNT_DATA] = 1'b1;
    end else if (if_valid) begin
      grant[GNT_FETCH] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single synchronous memory port.
// One access per three cycles: IDLE (accept) -> ISSUE (mem_en) -> RESP (rsp_valid).
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of data-first priority.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  // fetch port
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t         state_q;
  owner_t             owner_q;
  logic               we_q;
  owner_t             last_grant;
  logic [GRANT_W-1:0] grant;
  logic               if_acc;
  logic               d_acc;
  logic               accept;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;

  // Remember who was granted last so the next tie goes the other way.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_grant <= FETCH;
    else if (accept) last_grant <= d_acc ? DATA : FETCH;
  end
`else
  localparam bit RR_EN = 1'b0;

  assign last_grant = FETCH;
`endif

  arb_grant #(
    .RR_EN (RR_EN)
  ) u_arb_grant (
    .if_valid   (if_req_valid),
    .d_valid    (d_req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready only in IDLE and only for the winner; held low while reset is asserted.
  assign if_req_ready = reset_n && (state_q == IDLE) && grant[GNT_FETCH];
  assign d_req_ready  = reset_n && (state_q == IDLE) && grant[GNT_DATA];

  assign if_acc = if_req_valid && if_req_ready;
  assign d_acc  = d_req_valid && d_req_ready;
  assign accept = if_acc || d_acc;

  // Read data is forwarded straight from memory in the RESP cycle; writes return zero.
  assign if_rdata = (if_rsp_valid && !we_q) ? mem_rdata : '0;
  assign d_rdata  = (d_rsp_valid && !we_q)  ? mem_rdata : '0;

  // Access sequencer: captures the winning request and drives memory/response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= FETCH;
      we_q         <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= ISSUE;
            owner_q   <= d_acc ? DATA : FETCH;
            we_q      <= d_acc && d_we;
            mem_en    <= 1'b1;
            mem_we    <= d_acc && d_we;
            mem_addr  <= d_acc ? d_addr : if_addr;
            mem_wdata <= d_acc ? d_wdata : '0;
          end
        end
        ISSUE: begin
          state_q      <= RESP;
          mem_en       <= 1'b0;
          mem_we       <= 1'b0;
          mem_addr     <= '0;
          mem_wdata    <= '0;
          if_rsp_valid <= (owner_q == FETCH);
          d_rsp_valid  <= (owner_q == DATA);
        end
        RESP: begin
          state_q      <= IDLE;
          if_rsp_valid <= 1'b0;
          d_rsp_valid  <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          mem_en       <= 1'b0;
          mem_we       <= 1'b0;
          mem_addr     <= '0;
          mem_wdata    <= '0;
          if_rsp_valid <= 1'b0;
          d_rsp_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level schedule model.
// Build with +define+ARB_ROUND_ROBIN_EN to check the round-robin variant.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req_valid, d_req_ready, d_we, d_rsp_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_addr      (if_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rdata     (if_rdata),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_addr       (d_addr),
    .d_we         (d_we),
    .d_wdata      (d_wdata),
    .d_rsp_valid  (d_rsp_valid),
    .d_rdata      (d_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: cycle index, when the port is free again,
  // and the scheduled memory/response cycles of the access in flight.
  int          cyc;
  int          next_free;
  int          mem_cyc;
  int          rsp_cyc;
  int          rr_last;     // 0 = fetch, 1 = data
  int          e_owner;
  logic        e_we;
  logic [31:0] e_addr, e_wdata;

  // Observations of the last cycle, for scenario-level checks.
  logic        obs_if_acc, obs_d_acc, obs_if_ready;
  logic        obs_if_rsp, obs_d_rsp, obs_mem_we;
  logic [31:0] obs_if_rdata, obs_d_rdata, obs_mem_addr, obs_mem_wdata;

  function automatic int model_winner(input logic fv, input logic dv);
    if (fv && dv) return (RR && rr_last == 1) ? 0 : 1;
    if (dv) return 1;
    if (fv) return 0;
    return -1;
  endfunction

  task automatic model_reset();
    next_free = cyc;
    mem_cyc   = -1;
    rsp_cyc   = -1;
    rr_last   = 0;
  endtask

  // One clock cycle: inputs already set by the caller at posedge+1.
  task automatic run_cycle(input logic [31:0] rd);
    int   win;
    logic is_mem, is_rsp;
    mem_rdata = rd;
    #1;
    win = -1;
    if (cyc >= next_free) win = model_winner(if_req_valid, d_req_valid);
    is_mem = (cyc == mem_cyc);
    is_rsp = (cyc == rsp_cyc);
    check_eq("if_req_ready", 64'(if_req_ready), 64'(win == 0));
    check_eq("d_req_ready",  64'(d_req_ready),  64'(win == 1));
    check_eq("mem_en",    64'(mem_en),    64'(is_mem));
    check_eq("mem_we",    64'(mem_we),    64'(is_mem && e_we));
    check_eq("mem_addr",  64'(mem_addr),  is_mem ? 64'(e_addr)  : 64'(0));
    check_eq("mem_wdata", 64'(mem_wdata), is_mem ? 64'(e_wdata) : 64'(0));
    check_eq("if_rsp_valid", 64'(if_rsp_valid), 64'(is_rsp && e_owner == 0));
    check_eq("d_rsp_valid",  64'(d_rsp_valid),  64'(is_rsp && e_owner == 1));
    check_eq("if_rdata", 64'(if_rdata), (is_rsp && e_owner == 0 && !e_we) ? 64'(rd) : 64'(0));
    check_eq("d_rdata",  64'(d_rdata),  (is_rsp && e_owner == 1 && !e_we) ? 64'(rd) : 64'(0));
    obs_if_acc    = if_req_valid && if_req_ready;
    obs_d_acc     = d_req_valid && d_req_ready;
    obs_if_ready  = if_req_ready;
    obs_if_rsp    = if_rsp_valid;
    obs_d_rsp     = d_rsp_valid;
    obs_if_rdata  = if_rdata;
    obs_d_rdata   = d_rdata;
    obs_mem_we    = mem_we;
    obs_mem_addr  = mem_addr;
    obs_mem_wdata = mem_wdata;
    if (win >= 0) begin
      e_owner   = win;
      e_we      = (win == 1) ? d_we : 1'b0;
      e_addr    = (win == 1) ? d_addr : if_addr;
      e_wdata   = (win == 1) ? d_wdata : 32'h0;
      mem_cyc   = cyc + 1;
      rsp_cyc   = cyc + 2;
      next_free = cyc + 3;
      rr_last   = win;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (win == 0) if_req_valid = 1'b0;
    if (win == 1) d_req_valid  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             64'({if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_en, mem_we}), 64'(0));
    check_eq({tag, "_buses"},
             64'(if_rdata | d_rdata | mem_addr | mem_wdata), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[$];
    int acc_cyc[$];
    int n_data, n_fetch, n_rsp, sent;
    logic ready_seen;

    reset_n = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    d_req_valid = 1'b1; d_addr = 32'h4; d_we = 1'b0; d_wdata = '0;
    mem_rdata = 32'hFFFF_FFFF;
    cyc = 0;
    rr_last = 0;
    e_owner = 0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    #1;
    check_all_zero("reset");
    d_req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();

    // Both requesters valid for 12 cycles right after reset.
    seq.delete(); n_data = 0; n_fetch = 0; ready_seen = 1'b0;
    if_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if_req_valid = 1'b1;
      d_req_valid  = 1'b1;
      run_cycle($urandom);
      ready_seen |= obs_if_ready;
      if (obs_d_acc)  begin seq.push_back(1); n_data++;  end
      if (obs_if_acc) begin seq.push_back(0); n_fetch++; end
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    check_eq("tie_grants", 64'(seq.size()), 64'(4));
    if (RR) begin
      for (int i = 0; i < 4; i++)
        check_eq($sformatf("rr_order%0d", i), 64'(i < seq.size() ? seq[i] : -1), 64'((i % 2 == 0) ? 1 : 0));
    end else begin
      check_eq("fixed_data_grants", 64'(n_data), 64'(4));
      check_eq("fixed_fetch_grants", 64'(n_fetch), 64'(0));
      check_eq("fixed_if_ready_seen", 64'(ready_seen), 64'(0));
    end
    for (int i = 0; i < 3; i++) run_cycle($urandom);

    // Fetch-only read.
    if_addr = 32'h10; if_req_valid = 1'b1;
    run_cycle($urandom);
    check_eq("fetch_accept", 64'(obs_if_acc), 64'(1));
    run_cycle($urandom);
    check_eq("fetch_mem_addr", 64'(obs_mem_addr), 64'h10);
    run_cycle(32'hDEAD_BEEF);
    check_eq("fetch_rsp_valid", 64'(obs_if_rsp), 64'(1));
    check_eq("fetch_rdata", 64'(obs_if_rdata), 64'hDEAD_BEEF);

    // Data write.
    d_addr = 32'h100; d_wdata = 32'h55AA; d_we = 1'b1; d_req_valid = 1'b1;
    run_cycle($urandom);
    check_eq("write_accept", 64'(obs_d_acc), 64'(1));
    run_cycle($urandom);
    check_eq("write_mem_we", 64'(obs_mem_we), 64'(1));
    check_eq("write_mem_wdata", 64'(obs_mem_wdata), 64'h55AA);
    run_cycle(32'h1234_5678);
    check_eq("write_rsp_valid", 64'(obs_d_rsp), 64'(1));
    check_eq("write_rdata", 64'(obs_d_rdata), 64'(0));
    d_we = 1'b0;

    // Back-to-back fetches.
    acc_cyc.delete(); n_rsp = 0; sent = 0;
    for (int i = 0; i < 14; i++) begin
      if (!if_req_valid && sent < 3) begin
        if_addr = 32'h1000 + 32'(sent * 4);
        if_req_valid = 1'b1;
        sent++;
      end
      run_cycle($urandom);
      if (obs_if_acc) acc_cyc.push_back(cyc - 1);
      if (obs_if_rsp) n_rsp++;
    end
    check_eq("b2b_accepts", 64'(acc_cyc.size()), 64'(3));
    for (int i = 1; i < acc_cyc.size(); i++)
      check_eq($sformatf("b2b_gap%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(3));
    check_eq("b2b_rsp_count", 64'(n_rsp), 64'(3));

    // Reset asserted during ISSUE aborts the access.
    if_addr = 32'h80; if_req_valid = 1'b1;
    run_cycle($urandom);
    check_eq("abort_accept", 64'(obs_if_acc), 64'(1));
    check_eq("abort_in_issue", 64'(mem_en), 64'(1));
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge clk); #1;
    cyc++;
    reset_n = 1'b1;
    model_reset();
    n_rsp = 0;
    for (int i = 0; i < 5; i++) begin
      run_cycle($urandom);
      if (obs_if_rsp || obs_d_rsp) n_rsp++;
    end
    check_eq("abort_no_rsp", 64'(n_rsp), 64'(0));
    d_addr = 32'h44; d_we = 1'b0; d_req_valid = 1'b1;
    run_cycle($urandom);
    run_cycle($urandom);
    run_cycle(32'hCAFE_F00D);
    check_eq("post_reset_rsp", 64'(obs_d_rsp), 64'(1));
    check_eq("post_reset_rdata", 64'(obs_d_rdata), 64'hCAFE_F00D);

    // Randomized traffic; requesters hold valid and payload until accepted.
    for (int i = 0; i < 400; i++) begin
      if (!if_req_valid && ($urandom % 3 == 0)) begin
        if_addr = $urandom;
        if_req_valid = 1'b1;
      end
      if (!d_req_valid && ($urandom % 3 == 0)) begin
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_we    = 1'($urandom % 2);
        d_req_valid = 1'b1;
      end
      run_cycle($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
